// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes, register sentinel
// and the fetch-engine state encoding.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_HOLD   = 2'd1,
    S_HALTED = 2'd2,
    S_ERROR  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/ins_len_decode.sv
// Combinational icode -> instruction length and field-presence decode.
// Shared with the decode stage's legality checks.
module ins_len_decode
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  output logic [3:0] len,
  output logic       need_regids,
  output logic       need_valc,
  output logic       invalid
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    len         = 4'd1;
    need_regids = 1'b0;
    need_valc   = 1'b0;
    invalid     = 1'b0;
    case (icode)
      IHALT, INOP, IRET: ;
      IRRMOVQ, IOPQ, IPUSHQ, IPOPQ: begin
        len         = 4'd2;
        need_regids = 1'b1;
      end
      IJXX, ICALL: begin
        len       = 4'd9;
        need_valc = 1'b1;
      end
      IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
        len         = 4'd10;
        need_regids = 1'b1;
        need_valc   = 1'b1;
      end
      default: invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/ins_fetch_seq.sv
// Byte-serial Y86-64 fetch engine with valid/ready output and PC redirect.
// Optional FETCH_BOUNDS_CHECK_EN stops fetch with ADR at addresses >= IMEM_BYTES.
module ins_fetch_seq
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          IMEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] mem_addr,
  input  logic [7:0]  mem_byte,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [63:0] fetch_pc,
  output logic [2:0]  stat
);

  fetch_state_e state;
  logic [63:0]  pc;
  logic [63:0]  last_addr;
  logic [63:0]  byte_addr;
  logic [3:0]   cnt;
  logic [3:0]   len_r;
  logic         regids_r;
  logic         valc_r;
  logic         oob;
  logic [2:0]   valc_idx;
  logic [3:0]   dec_len;
  logic         dec_regids;
  logic         dec_valc;
  logic         dec_invalid;

  ins_len_decode u_len (
    .icode       (mem_byte[7:4]),
    .len         (dec_len),
    .need_regids (dec_regids),
    .need_valc   (dec_valc),
    .invalid     (dec_invalid)
  );

  assign byte_addr = pc + {60'd0, cnt};
  // valC byte slot: byte 1 (or 2 when a register byte precedes it) is slot 0.
  assign valc_idx  = cnt[2:0] - (regids_r ? 3'd2 : 3'd1);

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam logic [63:0] IMEM_LIMIT = 64'(IMEM_BYTES);
  assign oob = (byte_addr >= IMEM_LIMIT);
`else
  assign oob = 1'b0;
`endif

  // Outside active collection the last presented address is held.
  assign mem_addr = (state == S_FETCH && !oob) ? byte_addr : last_addr;

  always_ff @(posedge clk) begin
    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      last_addr <= RESET_PC;
      cnt       <= 4'd0;
      len_r     <= 4'd1;
      regids_r  <= 1'b0;
      valc_r    <= 1'b0;
      out_valid <= 1'b0;
      icode     <= 4'h0;
      ifun      <= 4'h0;
      rA        <= REG_NONE;
      rB        <= REG_NONE;
      valC      <= 64'd0;
      valP      <= 64'd0;
      fetch_pc  <= 64'd0;
      stat      <= SAOK;
    end else if (redirect_valid && (state == S_FETCH || state == S_HOLD)) begin
      pc        <= redirect_pc;
      cnt       <= 4'd0;
      state     <= S_FETCH;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (oob) begin
            // Out-of-range byte: present what was gathered so far as ADR.
            if (cnt == 4'd0) begin
              icode    <= 4'h0;
              ifun     <= 4'h0;
              rA       <= REG_NONE;
              rB       <= REG_NONE;
              valC     <= 64'd0;
              fetch_pc <= pc;
            end
            valP      <= byte_addr;
            stat      <= SADR;
            cnt       <= 4'd0;
            out_valid <= 1'b1;
            state     <= S_HOLD;
          end else begin
            last_addr <= byte_addr;
            if (cnt == 4'd0) begin
              icode    <= mem_byte[7:4];
              ifun     <= mem_byte[3:0];
              rA       <= REG_NONE;
              rB       <= REG_NONE;
              valC     <= 64'd0;
              fetch_pc <= pc;
              len_r    <= dec_len;
              regids_r <= dec_regids;
              valc_r   <= dec_valc;
              if (dec_len == 4'd1) begin
                valP      <= pc + 64'd1;
                stat      <= dec_invalid ? SINS : ((mem_byte[7:4] == IHALT) ? SHLT : SAOK);
                out_valid <= 1'b1;
                state     <= S_HOLD;
              end else begin
                cnt <= 4'd1;
              end
            end else begin
              if (regids_r && cnt == 4'd1) begin
                rA <= mem_byte[7:4];
                rB <= mem_byte[3:0];
              end else if (valc_r) begin
                valC[{valc_idx, 3'b000} +: 8] <= mem_byte;
              end
              if (cnt == len_r - 4'd1) begin
                valP      <= pc + {60'd0, len_r};
                stat      <= SAOK;
                cnt       <= 4'd0;
                out_valid <= 1'b1;
                state     <= S_HOLD;
              end else begin
                cnt <= cnt + 4'd1;
              end
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            case (stat)
              SAOK: begin
                pc    <= valP;
                state <= S_FETCH;
              end
              SHLT:    state <= S_HALTED;
              default: state <= S_ERROR;
            endcase
          end
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_ins_fetch_seq.sv
// Directed bench for ins_fetch_seq with a byte-wide combinational memory model.
// Build with FETCH_BOUNDS_CHECK_EN to exercise the ADR bound instead of wrap-through.
module tb_ins_fetch_seq;
  import y86_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] mem_addr;
  logic [7:0]  mem_byte;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP, fetch_pc;
  logic [2:0]  stat;

  logic [7:0]   imem [0:255];
  int           checks = 0;
  int           errors = 0;
  int           cyc;
  int           bad;
  logic [146:0] exp_f;

  assign mem_byte = imem[mem_addr[7:0]];

  always #5 clk = ~clk;

  ins_fetch_seq #(.RESET_PC(64'h0), .IMEM_BYTES(128)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_addr       (mem_addr),
    .mem_byte       (mem_byte),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .icode          (icode),
    .ifun           (ifun),
    .rA             (rA),
    .rB             (rB),
    .valC           (valC),
    .valP           (valP),
    .fetch_pc       (fetch_pc),
    .stat           (stat)
  );

  function automatic logic [146:0] obs();
    return {icode, ifun, rA, rB, valC, valP, stat};
  endfunction

  // Waits on falling edges until out_valid, reporting how many edges elapsed.
  task automatic wait_valid(input int max_cyc, output int n);
    n = 0;
    while (!out_valid && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic load_image();
    for (int i = 0; i < 256; i++) imem[i] = 8'h00;
    imem[8'h00] = 8'h60; imem[8'h01] = 8'h22;
    imem[8'h02] = 8'h80; imem[8'h03] = 8'h0e;
    imem[8'h0B] = 8'h10; imem[8'h0C] = 8'h10; imem[8'h0D] = 8'h10;
    imem[8'h0E] = 8'h30; imem[8'h0F] = 8'hf9; imem[8'h10] = 8'h45;
    imem[8'h18] = 8'h40; imem[8'h19] = 8'h12; imem[8'h1A] = 8'h22; imem[8'h1B] = 8'h11;
    imem[8'h22] = 8'h00;
    imem[8'h30] = 8'hC0;
    imem[8'h7C] = 8'h30; imem[8'h7D] = 8'hf3; imem[8'h7E] = 8'haa; imem[8'h7F] = 8'hbb;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, mem_addr} !== {1'b0, 64'h0}) begin
      errors++; $display("FAIL reset_valid_addr got %h exp %h", {out_valid, mem_addr}, {1'b0, 64'h0});
    end
    exp_f = {4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, SAOK};
    checks++;
    if (obs() !== exp_f || fetch_pc !== 64'h0) begin
      errors++; $display("FAIL reset_fields got %h/%h exp %h/0", obs(), fetch_pc, exp_f);
    end
    rst = 1'b0;
  endtask

  task automatic test_opq();
    out_ready = 1'b1;
    wait_valid(20, cyc);
    checks++;
    if (cyc !== 2) begin errors++; $display("FAIL opq_latency got %0d exp 2", cyc); end
    exp_f = {4'h6, 4'h0, 4'h2, 4'h2, 64'h0, 64'h2, SAOK};
    checks++;
    if (obs() !== exp_f || fetch_pc !== 64'h0) begin
      errors++; $display("FAIL opq_fields got %h/%h exp %h/0", obs(), fetch_pc, exp_f);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, mem_addr} !== {1'b0, 64'h2}) begin
      errors++; $display("FAIL opq_advance got %h exp %h", {out_valid, mem_addr}, {1'b0, 64'h2});
    end
  endtask

  task automatic test_call();
    wait_valid(20, cyc);
    checks++;
    if (cyc !== 9) begin errors++; $display("FAIL call_latency got %0d exp 9", cyc); end
    exp_f = {4'h8, 4'h0, 4'hF, 4'hF, 64'h0E, 64'h0B, SAOK};
    checks++;
    if (obs() !== exp_f || fetch_pc !== 64'h2) begin
      errors++; $display("FAIL call_fields got %h/%h exp %h/2", obs(), fetch_pc, exp_f);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      wait_valid(5, cyc);
      exp_f = {4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'(12 + i), SAOK};
      checks++;
      if (cyc !== 1 || obs() !== exp_f || fetch_pc !== 64'(11 + i)) begin
        errors++; $display("FAIL nop%0d got cyc %0d %h/%h exp cyc 1 %h", i, cyc, obs(), fetch_pc, exp_f);
      end
      @(negedge clk);
    end
    checks++;
    if ({out_valid, mem_addr} !== {1'b0, 64'h0E}) begin
      errors++; $display("FAIL nop_chain_addr got %h exp %h", {out_valid, mem_addr}, {1'b0, 64'h0E});
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    wait_valid(20, cyc);
    checks++;
    if (cyc !== 10) begin errors++; $display("FAIL irmov_latency got %0d exp 10", cyc); end
    exp_f = {4'h3, 4'h0, 4'hF, 4'h9, 64'h45, 64'h18, SAOK};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (!out_valid || obs() !== exp_f || fetch_pc !== 64'h0E || mem_addr !== 64'h17) begin
        errors++; $display("FAIL stall_hold%0d got v%b %h/%h a%h exp %h", i, out_valid, obs(), fetch_pc, mem_addr, exp_f);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, mem_addr} !== {1'b0, 64'h18}) begin
      errors++; $display("FAIL stall_release got %h exp %h", {out_valid, mem_addr}, {1'b0, 64'h18});
    end
  endtask

  task automatic test_redirect();
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    checks++;
    if (mem_addr !== 64'h1C || bad != 0) begin
      errors++; $display("FAIL redir_precount got a%h bad%0d exp a1c bad0", mem_addr, bad);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 64'h18;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if ({out_valid, mem_addr} !== {1'b0, 64'h18}) begin
      errors++; $display("FAIL redir_addr got %h exp %h", {out_valid, mem_addr}, {1'b0, 64'h18});
    end
    wait_valid(20, cyc);
    checks++;
    if (cyc !== 10) begin errors++; $display("FAIL redir_latency got %0d exp 10", cyc); end
    exp_f = {4'h4, 4'h0, 4'h1, 4'h2, 64'h1122, 64'h22, SAOK};
    checks++;
    if (obs() !== exp_f || fetch_pc !== 64'h18) begin
      errors++; $display("FAIL rmmov_fields got %h/%h exp %h/18", obs(), fetch_pc, exp_f);
    end
    @(negedge clk);
  endtask

  task automatic test_halt();
    wait_valid(5, cyc);
    exp_f = {4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h23, SHLT};
    checks++;
    if (cyc !== 1 || obs() !== exp_f) begin
      errors++; $display("FAIL halt_fields got cyc %0d %h exp cyc 1 %h", cyc, obs(), exp_f);
    end
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      redirect_valid = i[0];
      redirect_pc    = 64'h0;
      @(negedge clk);
      if (out_valid || mem_addr !== 64'h22) bad++;
    end
    redirect_valid = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL halted_stuck got %0d bad cycles exp 0", bad); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_f = {4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, SAOK};
    checks++;
    if (out_valid || mem_addr !== 64'h0 || obs() !== exp_f) begin
      errors++; $display("FAIL halt_reset got v%b a%h %h exp v0 a0 %h", out_valid, mem_addr, obs(), exp_f);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    checks++;
    if (mem_addr !== 64'h1) begin errors++; $display("FAIL midrst_cnt got %h exp 1", mem_addr); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({out_valid, mem_addr} !== {1'b0, 64'h0}) begin
      errors++; $display("FAIL midrst_addr got %h exp %h", {out_valid, mem_addr}, {1'b0, 64'h0});
    end
    wait_valid(20, cyc);
    exp_f = {4'h6, 4'h0, 4'h2, 4'h2, 64'h0, 64'h2, SAOK};
    checks++;
    if (cyc !== 2 || obs() !== exp_f) begin
      errors++; $display("FAIL midrst_refetch got cyc %0d %h exp cyc 2 %h", cyc, obs(), exp_f);
    end
  endtask

  task automatic test_redirect_handshake();
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0B;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if ({out_valid, mem_addr} !== {1'b0, 64'h0B}) begin
      errors++; $display("FAIL redir_hs_addr got %h exp %h", {out_valid, mem_addr}, {1'b0, 64'h0B});
    end
    wait_valid(5, cyc);
    exp_f = {4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0C, SAOK};
    checks++;
    if (cyc !== 1 || obs() !== exp_f || fetch_pc !== 64'h0B) begin
      errors++; $display("FAIL redir_hs_nop got cyc %0d %h/%h exp %h/0b", cyc, obs(), fetch_pc, exp_f);
    end
    @(negedge clk);
    checks++;
    if (mem_addr !== 64'h0C) begin errors++; $display("FAIL redir_hs_next got %h exp 0c", mem_addr); end
  endtask

  task automatic test_ins();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h30;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_valid(5, cyc);
    exp_f = {4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h31, SINS};
    checks++;
    if (cyc !== 1 || obs() !== exp_f) begin
      errors++; $display("FAIL ins_fields got cyc %0d %h exp cyc 1 %h", cyc, obs(), exp_f);
    end
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      redirect_valid = ~i[0];
      redirect_pc    = 64'h0;
      @(negedge clk);
      if (out_valid || mem_addr !== 64'h30) bad++;
    end
    redirect_valid = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL error_stuck got %0d bad cycles exp 0", bad); end
  endtask

  task automatic test_bounds();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h7C;
    @(negedge clk);
    redirect_valid = 1'b0;
    bad = 0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      if (mem_addr >= 64'h80) bad++;
      @(negedge clk);
      cyc++;
    end
`ifdef FETCH_BOUNDS_CHECK_EN
    checks++;
    if (cyc !== 5 || bad != 0) begin
      errors++; $display("FAIL bound_stop got cyc %0d oob %0d exp cyc 5 oob 0", cyc, bad);
    end
    checks++;
    if ({icode, rA, rB, valC, stat} !== {4'h3, 4'hF, 4'h3, 64'hbbaa, SADR} || mem_addr !== 64'h7F) begin
      errors++; $display("FAIL bound_fields got %h a%h exp %h a7f", {icode, rA, rB, valC, stat}, mem_addr,
                         {4'h3, 4'hF, 4'h3, 64'hbbaa, SADR});
    end
`else
    checks++;
    if (cyc !== 10 || bad != 6) begin
      errors++; $display("FAIL nobound_pass got cyc %0d high %0d exp cyc 10 high 6", cyc, bad);
    end
    exp_f = {4'h3, 4'h0, 4'hF, 4'h3, 64'hbbaa, 64'h86, SAOK};
    checks++;
    if (obs() !== exp_f) begin
      errors++; $display("FAIL nobound_fields got %h exp %h", obs(), exp_f);
    end
`endif
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bound_consume got %b exp 0", out_valid); end
  endtask

  initial begin
    load_image();
    test_reset();
    test_opq();
    test_call();
    test_back_to_back();
    test_stall();
    test_redirect();
    test_halt();
    test_mid_reset();
    test_redirect_handshake();
    test_ins();
    test_bounds();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
